row_clear_ctrl: RTL
===================

# row_clear_ctrl

Sequencer that runs line clearing after a piece lands. It gates the complete-row scanner, sweeps the whole board for full rows, and collapses each full row by shifting every row above it down one position through a row-write port into the fallen-pieces register. It freezes game play while it works and reports how many lines were cleared. It sits between the game FSM (landing event, pause) and the board register / `complete_row` scanner.

## Interface
Parameters:
- `BLOCKS_WIDE`, 10: board width in cells
- `BLOCKS_HIGH`, 22: board height in rows; row 0 is the top
- `BITS_Y_POS`, 5: row index width; must satisfy 2^BITS_Y_POS ≥ BLOCKS_HIGH

Ports:
- `clk` in 1: single clock; every register updates on its rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `piece_landed` in 1: one-cycle pulse; the piece has been merged into the board
- `fallen_pieces` in BLOCKS_WIDE*BLOCKS_HIGH: current board; row r occupies bits [r*BLOCKS_WIDE +: BLOCKS_WIDE]
- `scan_row` in BITS_Y_POS: row the scanner is currently testing
- `scan_complete` in 1: scanner reports that `scan_row` is full
- `scan_pause` out 1: holds the scanner
- `game_pause` out 1: freezes gravity and input
- `wr_en` out 1: board row write strobe
- `wr_row` out BITS_Y_POS: row to overwrite
- `wr_data` out BLOCKS_WIDE: new contents for that row
- `lines_cleared` out 3: rows cleared by the last landing, saturating at 7
- `done` out 1: one-cycle pulse when the sequence finishes

## Operation
- States:
  - IDLE → SCAN on `piece_landed`; this also clears `lines_cleared` to 0 and `sweep_cnt` to 0.
  - SCAN → SHIFT on the first sampled `scan_complete`; this latches `cur = scan_row` and increments `lines_cleared` (saturating at 7).
  - SCAN → DONE when `sweep_cnt` reaches BLOCKS_HIGH-1 with no hit.
  - SHIFT → SCAN after the write with `cur == 0`; `sweep_cnt` resets to 0.
  - DONE → IDLE unconditionally.
- SCAN:
  - `scan_pause` is 0, so the scanner advances one row per cycle.
  - The block samples `scan_complete` every cycle and increments `sweep_cnt` each cycle. One full sweep is BLOCKS_HIGH cycles, regardless of the row the scanner starts on.
- SHIFT:
  - One row per cycle: `wr_en` = 1, `wr_row` = `cur`.
  - `wr_data` = row `cur`-1 of `fallen_pieces`, or all zeros when `cur` = 0.
  - `cur` decrements each cycle.
  - A clear of row R takes R+1 cycles.
- After every SHIFT a fresh full sweep runs. Several full rows are therefore cleared one at a time, including rows that were shifted down into already-swept positions.
- Write outputs are combinational from state, `cur` and `fallen_pieces`. The board owner commits the write at the same rising edge, so the next cycle sees the updated board.
- `scan_pause` = (state != SCAN).
- `game_pause` = (state != IDLE).
- `done` = (state == DONE).
- `lines_cleared` is a register; it holds its value from DONE until the next accepted `piece_landed`.
- `piece_landed` outside IDLE is ignored; it is neither queued nor counted.

## Timing
- Reset values:
  - state IDLE, `cur` 0, `sweep_cnt` 0
  - `scan_pause` 1, `game_pause` 0, `wr_en` 0, `wr_row` 0, `wr_data` 0
  - `lines_cleared` 0, `done` 0
- Reset mid-operation: aborts immediately, with no further writes. A partially shifted board is left as-is.
- No full row: `piece_landed` is sampled at edge E. SCAN covers cycles E..E+BLOCKS_HIGH-1. `done` is high in cycle E+BLOCKS_HIGH, then IDLE.
- One full row R, first hit after k SCAN cycles: latency = k + (R+1) + BLOCKS_HIGH + 1 cycles to `done`.
- Hit in the final sweep cycle: SHIFT takes priority over DONE.
- In the cycle SCAN→SHIFT, the scanner advances once more; this is harmless.
- `sweep_cnt` width is BITS_Y_POS. `cur` never underflows, because SHIFT exits at 0.

## Structure
- Shared package / `definitions.vh`: BLOCKS_WIDE, BLOCKS_HIGH, BITS_Y_POS, and the state encoding (IDLE=0, SCAN=1, SHIFT=2, DONE=3).
- No sub-module. The scanner stays a separate instance driven by `scan_pause`.
- The bench instantiates `row_clear_ctrl`, the scanner and a behavioural board register that applies `wr_*`.

## Test plan
- Empty board, pulse `piece_landed` → `done` exactly BLOCKS_HIGH cycles after the pulse edge; `lines_cleared` = 0; `wr_en` never 1.
- Row 21 full, row 20 = 10'b0000000001 → after `done`: row 21 = 10'b0000000001, row 0 = 0, `lines_cleared` = 1, exactly 22 write cycles.
- Rows 20 and 21 full, row 19 = 10'b1000000000 → final row 21 = 10'b1000000000, rows 0–1 = 0, `lines_cleared` = 2.
- Row 0 full only → a single write (row 0 ← 0), `lines_cleared` = 1, `game_pause` high throughout.
- `piece_landed` pulsed during SHIFT → no restart; `lines_cleared` is unchanged by it; exactly one `done` pulse.
- `rst_n` low for one cycle mid-SHIFT → immediately `wr_en` 0, `scan_pause` 1, `game_pause` 0, state IDLE; the next `piece_landed` runs normally.

Source files
------------

// File: rtl/row_clear_ctrl_pkg.sv
// Shared board geometry, sequencer state encoding and a small saturating
// counter helper for the line-clear sequencer.
package row_clear_ctrl_pkg;

    // Default board geometry; row 0 is the top of the board.
    localparam int BLOCKS_WIDE = 10;
    localparam int BLOCKS_HIGH = 22;
    localparam int BITS_Y_POS  = 5;

    // Cleared-line count is 3 bits wide and sticks at its maximum.
    localparam logic [2:0] LINES_MAX = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Increment a 3-bit count without wrapping past LINES_MAX.
    function automatic logic [2:0] sat_inc3(input logic [2:0] value);
        return (value == LINES_MAX) ? value : value + 3'd1;
    endfunction

endpackage

// File: rtl/row_clear_ctrl_if.sv
// Scanner control and board row-write port of the line-clear sequencer.
// The master side is the sequencer; the slave side is the scanner plus the
// board register that commits the row writes.
interface row_clear_ctrl_if #(
    parameter int BLOCKS_WIDE = row_clear_ctrl_pkg::BLOCKS_WIDE,
    parameter int BITS_Y_POS  = row_clear_ctrl_pkg::BITS_Y_POS
);

    logic                   scan_pause;
    logic [BITS_Y_POS-1:0]  scan_row;
    logic                   scan_complete;
    logic                   wr_en;
    logic [BITS_Y_POS-1:0]  wr_row;
    logic [BLOCKS_WIDE-1:0] wr_data;

    modport master (
        output scan_pause,
        output wr_en,
        output wr_row,
        output wr_data,
        input  scan_row,
        input  scan_complete
    );

    modport slave (
        input  scan_pause,
        input  wr_en,
        input  wr_row,
        input  wr_data,
        output scan_row,
        output scan_complete
    );

endinterface

// File: rtl/row_clear_ctrl.sv
// Line-clear sequencer. After a piece lands it freezes play, lets the
// complete-row scanner sweep the board, and collapses each full row it finds
// by copying every row above it down one position, top row filled with zeros.
// A fresh full sweep follows every collapse so rows that slide into already
// swept positions are still caught.
module row_clear_ctrl #(
    parameter int BLOCKS_WIDE = row_clear_ctrl_pkg::BLOCKS_WIDE,
    parameter int BLOCKS_HIGH = row_clear_ctrl_pkg::BLOCKS_HIGH,
    parameter int BITS_Y_POS  = row_clear_ctrl_pkg::BITS_Y_POS
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               piece_landed,
    input  logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] fallen_pieces,
    output logic                               game_pause,
    output logic [2:0]                         lines_cleared,
    output logic                               done,
    row_clear_ctrl_if.master                   bus
);

    import row_clear_ctrl_pkg::*;

    localparam logic [BITS_Y_POS-1:0] LAST_SWEEP = BITS_Y_POS'(BLOCKS_HIGH - 1);
    localparam logic [BITS_Y_POS-1:0] ONE        = BITS_Y_POS'(1);

    state_e                state_q, state_d;
    logic [BITS_Y_POS-1:0] cur_q, cur_d;
    logic [BITS_Y_POS-1:0] sweep_cnt_q, sweep_cnt_d;
    logic [2:0]            lines_q, lines_d;

    // State, shift cursor, sweep counter and line count; reset abandons any sweep or shift in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            sweep_cnt_q <= '0;
            lines_q     <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            sweep_cnt_q <= sweep_cnt_d;
            lines_q     <= lines_d;
        end
    end

    // Sequencing: a hit during a sweep wins over the sweep ending, and a collapse always restarts a full sweep
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        sweep_cnt_d = sweep_cnt_q;
        lines_d     = lines_q;
        case (state_q)
            IDLE: begin
                if (piece_landed) begin
                    state_d     = SCAN;
                    lines_d     = '0;
                    sweep_cnt_d = '0;
                end
            end
            SCAN: begin
                if (bus.scan_complete) begin
                    state_d     = SHIFT;
                    cur_d       = bus.scan_row;
                    lines_d     = sat_inc3(lines_q);
                    sweep_cnt_d = '0;
                end else if (sweep_cnt_q == LAST_SWEEP) begin
                    state_d = DONE;
                end else begin
                    sweep_cnt_d = sweep_cnt_q + ONE;
                end
            end
            SHIFT: begin
                if (cur_q == '0) begin
                    state_d     = SCAN;
                    sweep_cnt_d = '0;
                end else begin
                    cur_d = cur_q - ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Row write port: while collapsing, row cur takes the contents of the row above it, or zeros at the top
    always_comb begin
        bus.wr_en   = 1'b0;
        bus.wr_row  = '0;
        bus.wr_data = '0;
        if (state_q == SHIFT) begin
            bus.wr_en  = 1'b1;
            bus.wr_row = cur_q;
            if (cur_q != '0) begin
                for (int r = 0; r < BLOCKS_HIGH; r++) begin
                    if (cur_q == BITS_Y_POS'(r + 1)) begin
                        bus.wr_data = fallen_pieces[r*BLOCKS_WIDE +: BLOCKS_WIDE];
                    end
                end
            end
        end
    end

    assign bus.scan_pause = (state_q != SCAN);
    assign game_pause     = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign lines_cleared  = lines_q;

endmodule
